biu_hs: RTL and testbench
=========================

BIU_HS -- requirements
Module: biu_hs

Interface
REQ-001 Parameters: ITIM_AW, 12, ITIM word-address width.
REQ-002 Parameters: DTIM_AW, 12, DTIM word-address width.
REQ-003 Parameters: DTIM_BASE, 32'h8000_0000, DTIM byte base; DTIM spans 4*2^DTIM_AW bytes.
REQ-004 Parameters: TIMEOUT, 255, maximum REQ cycles before bus error, range 1..65535.
REQ-005 Parameters: ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout.
REQ-006 Ports: clk  in  1  single clock, rising edge.
REQ-007 Ports: rst  in  1  asynchronous, active-low reset.
REQ-008 Ports: biu_i_iaddr  in  32  fetch byte address; biu_o_idata  out  32  fetch data.
REQ-009 Ports: biu_i_daddr  in  32, biu_i_dren  in  1, biu_i_dwmask  in  4, biu_i_dwdata  in  32  core data request; biu_o_drdata  out  32  load data.
REQ-010 Ports: biu_o_halt  out  1  stall core; biu_o_bus_err  out  1  one-cycle timeout pulse; biu_o_err_addr  out  32  address of last timed-out access.
REQ-011 Ports: biu_o_itim_addr  out  ITIM_AW, biu_i_itim_rdata  in  32.
REQ-012 Ports: biu_o_dtim_addr  out  DTIM_AW, biu_o_dtim_wmask  out  4, biu_o_dtim_wdata  out  32, biu_i_dtim_rdata  in  32 (combinational read).
REQ-013 Ports: biu_o_mmio_valid  out  1, biu_i_mmio_ready  in  1, biu_o_mmio_addr  out  32, biu_o_mmio_wmask  out  4, biu_o_mmio_wdata  out  32, biu_i_mmio_rdata  in  32.

Function
REQ-014 Fetch SHALL be combinational: itim_addr = iaddr[ITIM_AW+1:2], idata = itim_rdata.
REQ-015 Data access active = dren or |dwmask; DTIM hit when daddr in [DTIM_BASE, DTIM_BASE+4*2^DTIM_AW); all other active accesses SHALL be MMIO.
REQ-016 DTIM hit SHALL complete same cycle: dtim_addr = daddr[DTIM_AW+1:2], dtim_wmask = dwmask, drdata = dtim_rdata, halt = 0.
REQ-017 DTIM wmask SHALL be 0 for any non-DTIM or inactive access.
REQ-018 FSM states IDLE, REQ, DONE, ERR; reset state IDLE.
REQ-019 IDLE + active MMIO: halt = 1 combinationally; register daddr, dwmask, dwdata; next REQ, timeout counter cleared.
REQ-020 REQ: mmio_valid = 1, halt = 1; addr/wmask/wdata SHALL hold registered values, stable until ready.
REQ-021 REQ + ready: capture mmio_rdata; next DONE; valid deasserts next cycle.
REQ-022 REQ + !ready: counter increments; when counter reaches TIMEOUT-1 without ready, next ERR, err_addr <= registered address.
REQ-023 Ready and timeout in same cycle: ready SHALL win (DONE).
REQ-024 DONE: halt = 0, drdata = captured data, no new request accepted this cycle; next IDLE.
REQ-025 ERR: halt = 0, bus_err = 1, drdata = ERR_DATA; next IDLE.
REQ-026 MMIO latency: ready sampled in REQ cycle n (n>=1) -> instruction retires in cycle n+1; minimum 3 cycles total.
REQ-027 Counter SHALL be 16 bits, saturating, never wraps.
REQ-028 mmio_valid SHALL be 0 in IDLE, DONE, ERR; ready outside REQ SHALL be ignored.
REQ-029 drdata SHALL be 0 when no access active in IDLE.

Reset
REQ-030 On rst low: state IDLE, counter 0, captured data 0, err_addr 0, mmio_valid 0, bus_err 0, registered addr/wmask/wdata 0, immediately (asynchronous).
REQ-031 Reset during REQ SHALL drop mmio_valid in the same cycle; in-flight access abandoned, no bus_err.
REQ-032 First request accepted in first rising edge after rst deasserts.

Structure
REQ-033 Shared package holds FSM state encoding (2-bit), default base/size constants, ERR_DATA default.
REQ-034 One sub-module natural: biu_decode (combinational DTIM/MMIO region decode); FSM, counter, capture registers in biu_hs.

Verification
REQ-035 Load daddr 32'h8000_0010 dren=1 -> dtim_addr 4, drdata = dtim_rdata same cycle, halt 0.
REQ-036 Store 32'h1000_0004 wmask 4'hF wdata 32'h1234_5678, ready on 3rd REQ cycle -> valid high 3 cycles with stable addr/data, halt 0 on cycle 5, dtim_wmask 0 throughout.
REQ-037 MMIO load, ready never asserted, TIMEOUT=4 -> ERR after 4 REQ cycles, bus_err one pulse, drdata 32'hDEAD_BEEF, err_addr = request address.
REQ-038 Ready asserted exactly on TIMEOUT-1 count -> DONE, no bus_err, captured rdata returned.
REQ-039 rst low mid-REQ -> valid 0 same cycle, state IDLE, no bus_err; post-reset MMIO access completes normally.

Source files
------------

// File: rtl/biu_hs_pkg.sv
// Shared definitions for the hart bus interface unit: FSM encoding,
// default memory map constants and small helpers.
package biu_hs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } biu_state_e;

    localparam int          CNT_W         = 16;
    localparam int          ITIM_AW_DEF   = 12;
    localparam int          DTIM_AW_DEF   = 12;
    localparam logic [31:0] DTIM_BASE_DEF = 32'h8000_0000;
    localparam int          TIMEOUT_DEF   = 255;
    localparam logic [31:0] ERR_DATA_DEF  = 32'hDEAD_BEEF;

    // Saturating increment keeps the timeout counter from ever wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/biu_decode.sv
// Combinational data-side region decode: splits an active core access into
// a DTIM hit or an MMIO transaction.
module biu_decode
    import biu_hs_pkg::*;
#(
    parameter int          DTIM_AW   = DTIM_AW_DEF,
    parameter logic [31:0] DTIM_BASE = DTIM_BASE_DEF
) (
    input  logic [31:0] daddr,
    input  logic        dren,
    input  logic [3:0]  dwmask,
    output logic        dtim_hit,
    output logic        mmio_hit
);

    localparam logic [32:0] DTIM_BYTES = 33'd4 << DTIM_AW;

    logic        active;
    logic [32:0] offset;
    logic        in_dtim;

    assign active = dren | (|dwmask);

    // A 33-bit offset makes addresses below the base wrap to a huge value,
    // so one unsigned compare covers both ends of the window.
    assign offset  = {1'b0, daddr} - {1'b0, DTIM_BASE};
    assign in_dtim = (offset < DTIM_BYTES);

    assign dtim_hit = active & in_dtim;
    assign mmio_hit = active & ~in_dtim;

endmodule

// File: rtl/biu_hs.sv
// Bus interface unit: combinational ITIM fetch, single-cycle DTIM access and
// a stalling MMIO valid/ready handshake with timeout-driven bus error.
module biu_hs
    import biu_hs_pkg::*;
#(
    parameter int          ITIM_AW   = ITIM_AW_DEF,
    parameter int          DTIM_AW   = DTIM_AW_DEF,
    parameter logic [31:0] DTIM_BASE = DTIM_BASE_DEF,
    parameter int          TIMEOUT   = TIMEOUT_DEF,
    parameter logic [31:0] ERR_DATA  = ERR_DATA_DEF
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [31:0]        biu_i_iaddr,
    output logic [31:0]        biu_o_idata,

    input  logic [31:0]        biu_i_daddr,
    input  logic               biu_i_dren,
    input  logic [3:0]         biu_i_dwmask,
    input  logic [31:0]        biu_i_dwdata,
    output logic [31:0]        biu_o_drdata,

    output logic               biu_o_halt,
    output logic               biu_o_bus_err,
    output logic [31:0]        biu_o_err_addr,

    output logic [ITIM_AW-1:0] biu_o_itim_addr,
    input  logic [31:0]        biu_i_itim_rdata,

    output logic [DTIM_AW-1:0] biu_o_dtim_addr,
    output logic [3:0]         biu_o_dtim_wmask,
    output logic [31:0]        biu_o_dtim_wdata,
    input  logic [31:0]        biu_i_dtim_rdata,

    output logic               biu_o_mmio_valid,
    input  logic               biu_i_mmio_ready,
    output logic [31:0]        biu_o_mmio_addr,
    output logic [3:0]         biu_o_mmio_wmask,
    output logic [31:0]        biu_o_mmio_wdata,
    input  logic [31:0]        biu_i_mmio_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    biu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q;
    logic [3:0]       wmask_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic [31:0]      err_addr_q;
    logic             mmio_valid_q;
    logic             bus_err_q;

    logic             dtim_hit;
    logic             mmio_hit;
    logic             idle;
    logic             unused_iaddr;

    biu_decode #(
        .DTIM_AW   (DTIM_AW),
        .DTIM_BASE (DTIM_BASE)
    ) u_decode (
        .daddr    (biu_i_daddr),
        .dren     (biu_i_dren),
        .dwmask   (biu_i_dwmask),
        .dtim_hit (dtim_hit),
        .mmio_hit (mmio_hit)
    );

    assign biu_o_itim_addr = biu_i_iaddr[ITIM_AW+1:2];
    assign biu_o_idata     = biu_i_itim_rdata;
    assign unused_iaddr    = ^{biu_i_iaddr[31:ITIM_AW+2], biu_i_iaddr[1:0]};

    assign idle = (state == ST_IDLE);

    // DTIM writes only fire in IDLE so a held MMIO access can never leak a
    // write into the tightly coupled memory.
    assign biu_o_dtim_addr  = biu_i_daddr[DTIM_AW+1:2];
    assign biu_o_dtim_wmask = (idle && dtim_hit) ? biu_i_dwmask : 4'h0;
    assign biu_o_dtim_wdata = biu_i_dwdata;

    assign biu_o_mmio_valid = mmio_valid_q;
    assign biu_o_mmio_addr  = addr_q;
    assign biu_o_mmio_wmask = wmask_q;
    assign biu_o_mmio_wdata = wdata_q;
    assign biu_o_bus_err    = bus_err_q;
    assign biu_o_err_addr   = err_addr_q;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        biu_o_halt   = 1'b0;
        biu_o_drdata = '0;
        case (state)
            ST_IDLE: begin
                biu_o_halt = mmio_hit;
                if (dtim_hit) biu_o_drdata = biu_i_dtim_rdata;
            end
            ST_REQ:  biu_o_halt   = 1'b1;
            ST_DONE: biu_o_drdata = rdata_q;
            ST_ERR:  biu_o_drdata = ERR_DATA;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            wmask_q      <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_addr_q   <= '0;
            mmio_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            bus_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mmio_hit) begin
                        addr_q       <= biu_i_daddr;
                        wmask_q      <= biu_i_dwmask;
                        wdata_q      <= biu_i_dwdata;
                        cnt          <= '0;
                        mmio_valid_q <= 1'b1;
                        state        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ready is checked first so a late response beats the timeout.
                    if (biu_i_mmio_ready) begin
                        rdata_q      <= biu_i_mmio_rdata;
                        mmio_valid_q <= 1'b0;
                        state        <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        err_addr_q   <= addr_q;
                        mmio_valid_q <= 1'b0;
                        bus_err_q    <= 1'b1;
                        state        <= ST_ERR;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_biu_hs.sv
// Randomized scoreboard bench for biu_hs with DTIM, ITIM and MMIO slave
// models and a reference model of the memory map and handshake timing.
module tb_biu_hs;

    localparam int          ITIM_AW    = 6;
    localparam int          DTIM_AW    = 6;
    localparam int          TIMEOUT    = 4;
    localparam logic [31:0] DTIM_BASE  = 32'h8000_0000;
    localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;
    localparam logic [31:0] DTIM_BYTES = 32'(4 << DTIM_AW);

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [31:0] err_addr;
        int          cycles;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        iaddr, idata;
    logic [31:0]        daddr, dwdata, drdata;
    logic               dren;
    logic [3:0]         dwmask;
    logic               halt, bus_err;
    logic [31:0]        err_addr;
    logic [ITIM_AW-1:0] itim_addr;
    logic [31:0]        itim_rdata;
    logic [DTIM_AW-1:0] dtim_addr;
    logic [3:0]         dtim_wmask;
    logic [31:0]        dtim_wdata, dtim_rdata;
    logic               mmio_valid, mmio_ready;
    logic [31:0]        mmio_addr, mmio_wdata, mmio_rdata;
    logic [3:0]         mmio_wmask;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] dmem[2**DTIM_AW];
    logic [31:0] dref[2**DTIM_AW];
    logic [31:0] last_err;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_wmask;
    logic        cur_dtim;
    int          cur_lat;

    biu_hs #(
        .ITIM_AW   (ITIM_AW),
        .DTIM_AW   (DTIM_AW),
        .DTIM_BASE (DTIM_BASE),
        .TIMEOUT   (TIMEOUT),
        .ERR_DATA  (ERR_DATA)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .biu_i_iaddr      (iaddr),
        .biu_o_idata      (idata),
        .biu_i_daddr      (daddr),
        .biu_i_dren       (dren),
        .biu_i_dwmask     (dwmask),
        .biu_i_dwdata     (dwdata),
        .biu_o_drdata     (drdata),
        .biu_o_halt       (halt),
        .biu_o_bus_err    (bus_err),
        .biu_o_err_addr   (err_addr),
        .biu_o_itim_addr  (itim_addr),
        .biu_i_itim_rdata (itim_rdata),
        .biu_o_dtim_addr  (dtim_addr),
        .biu_o_dtim_wmask (dtim_wmask),
        .biu_o_dtim_wdata (dtim_wdata),
        .biu_i_dtim_rdata (dtim_rdata),
        .biu_o_mmio_valid (mmio_valid),
        .biu_i_mmio_ready (mmio_ready),
        .biu_o_mmio_addr  (mmio_addr),
        .biu_o_mmio_wmask (mmio_wmask),
        .biu_o_mmio_wdata (mmio_wdata),
        .biu_i_mmio_rdata (mmio_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] itim_data(input logic [5:0] i);
        return {i, 2'b01, ~i, 2'b10, i, 2'b11, ~i, 2'b00};
    endfunction

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    function automatic logic in_dtim(input logic [31:0] a);
        logic [63:0] a64;
        a64 = {32'h0, a};
        return (a64 >= 64'(DTIM_BASE)) && (a64 < 64'(DTIM_BASE) + 64'(DTIM_BYTES));
    endfunction

    function automatic logic [31:0] rand_mmio();
        case ($urandom_range(0, 3))
            0:       return $urandom & 32'h7FFF_FFFF;
            1:       return DTIM_BASE + DTIM_BYTES + ($urandom & 32'h0FFF_FFFF);
            2:       return DTIM_BASE - 32'd4;
            default: return DTIM_BASE + DTIM_BYTES;
        endcase
    endfunction

    assign itim_rdata = itim_data(itim_addr);
    assign dtim_rdata = dmem[dtim_addr];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (dtim_wmask[b]) dmem[dtim_addr][8*b +: 8] <= dtim_wdata[8*b +: 8];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // MMIO slave: ready on the cur_lat-th REQ cycle; stray ready while idle.
    initial begin
        int n = 0;
        mmio_ready = 1'b0;
        mmio_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            n = mmio_valid ? n + 1 : 0;
            if (mmio_valid && n == cur_lat) begin
                mmio_ready = 1'b1;
                mmio_rdata = slave_data(mmio_addr);
            end else begin
                mmio_ready = !mmio_valid && ($urandom_range(0, 3) == 0);
                mmio_rdata = $urandom;
            end
        end
    end

    // Monitor: compares every retirement against the scoreboard head.
    initial begin
        int   cyc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cyc = 0;
            end else begin
                check("itim_addr", 32'(itim_addr), 32'(iaddr[7:2]));
                check("idata", idata, itim_data(iaddr[7:2]));
                if (dren || dwmask != 4'h0) begin
                    cyc++;
                    check("dtim_wmask", 32'(dtim_wmask), 32'(cur_dtim ? dwmask : 4'h0));
                    if (mmio_valid) begin
                        check("mmio_addr", mmio_addr, cur_addr);
                        check("mmio_wmask", 32'(mmio_wmask), 32'(cur_wmask));
                        check("mmio_wdata", mmio_wdata, cur_wdata);
                    end
                    if (!halt) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_retire actual=%h required=none", drdata);
                        end else begin
                            e = sb.pop_front();
                            check("drdata", drdata, e.data);
                            check("bus_err", 32'(bus_err), 32'(e.err));
                            check("err_addr", err_addr, e.err_addr);
                            check("latency", cyc, e.cycles);
                            check("valid_at_retire", 32'(mmio_valid), 32'd0);
                        end
                        cyc = 0;
                    end
                end else begin
                    check("idle_drdata", drdata, 32'd0);
                    check("idle_halt", 32'(halt), 32'd0);
                    check("idle_bus_err", 32'(bus_err), 32'd0);
                    check("idle_valid", 32'(mmio_valid), 32'd0);
                    check("idle_dtim_wmask", 32'(dtim_wmask), 32'd0);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic rd, input logic [3:0] wm,
                         input logic [31:0] wd, input int lat);
        exp_t e;
        int   idx;
        @(posedge clk);
        #1;
        daddr     = a;
        dren      = rd;
        dwmask    = wm;
        dwdata    = wd;
        iaddr     = $urandom;
        cur_addr  = a;
        cur_wmask = wm;
        cur_wdata = wd;
        cur_lat   = lat;
        cur_dtim  = in_dtim(a);
        if (cur_dtim) begin
            idx    = int'((a - DTIM_BASE) >> 2);
            e.data = dref[idx];
            for (int b = 0; b < 4; b++)
                if (wm[b]) dref[idx][8*b +: 8] = wd[8*b +: 8];
            e.err    = 1'b0;
            e.cycles = 1;
        end else if (lat <= TIMEOUT) begin
            e.data   = slave_data(a);
            e.err    = 1'b0;
            e.cycles = lat + 2;
        end else begin
            e.data   = ERR_DATA;
            e.err    = 1'b1;
            last_err = a;
            e.cycles = TIMEOUT + 2;
        end
        e.err_addr = last_err;
        sb.push_back(e);
    endtask

    task automatic wait_retire();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (halt && n < 40);
        check("retire_bound", 32'(halt), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            dren   = 1'b0;
            dwmask = 4'h0;
            daddr  = $urandom;
            dwdata = $urandom;
            iaddr  = $urandom;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  wm;
        logic        rd;
        rst      = 1'b0;
        iaddr    = '0;
        daddr    = '0;
        dren     = 1'b0;
        dwmask   = 4'h0;
        dwdata   = '0;
        last_err = '0;
        cur_addr = '0;
        cur_wmask = '0;
        cur_wdata = '0;
        cur_dtim = 1'b0;
        cur_lat  = 1;
        for (int i = 0; i < 2**DTIM_AW; i++) begin
            dmem[i] = $urandom;
            dref[i] = dmem[i];
        end

        #1;
        check("rst_valid", 32'(mmio_valid), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        check("rst_mmio_addr", mmio_addr, 32'd0);
        check("rst_mmio_wmask", 32'(mmio_wmask), 32'd0);
        check("rst_mmio_wdata", mmio_wdata, 32'd0);
        check("rst_drdata", drdata, 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Directed cases: DTIM load, stretched store, timeout, late ready, edges.
        issue(32'h8000_0010, 1'b1, 4'h0, 32'h0, 1);
        #1;
        check("dtim_addr_load", 32'(dtim_addr), 32'd4);
        check("dtim_halt", 32'(halt), 32'd0);
        wait_retire();
        issue(32'h1000_0004, 1'b0, 4'hF, 32'h1234_5678, 3);
        wait_retire();
        issue(32'h2000_0040, 1'b1, 4'h0, 32'h0, 99);
        wait_retire();
        issue(32'h3000_0008, 1'b1, 4'h0, 32'h0, TIMEOUT);
        wait_retire();
        issue(DTIM_BASE + DTIM_BYTES - 32'd4, 1'b0, 4'b0101, 32'hA1B2_C3D4, 1);
        wait_retire();
        issue(DTIM_BASE + DTIM_BYTES - 32'd4, 1'b1, 4'h0, 32'h0, 1);
        wait_retire();
        issue(DTIM_BASE + DTIM_BYTES, 1'b1, 4'h0, 32'h0, 2);
        wait_retire();
        issue(DTIM_BASE - 32'd4, 1'b1, 4'h0, 32'h0, 1);
        wait_retire();

        // Reset in the middle of an outstanding MMIO request.
        issue(32'h4000_0000, 1'b1, 4'h0, 32'h0, 99);
        @(negedge clk);
        @(negedge clk);
        check("valid_pre_rst", 32'(mmio_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_valid", 32'(mmio_valid), 32'd0);
        check("rst_mid_bus_err", 32'(bus_err), 32'd0);
        check("rst_mid_err_addr", err_addr, 32'd0);
        dren     = 1'b0;
        dwmask   = 4'h0;
        last_err = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        issue(32'h5000_0010, 1'b1, 4'h0, 32'h0, 2);
        wait_retire();

        repeat (300) begin
            if ($urandom_range(0, 9) < 5)
                a = DTIM_BASE + 32'(4 * $urandom_range(0, 2**DTIM_AW - 1)) + 32'($urandom_range(0, 3));
            else
                a = rand_mmio();
            case ($urandom_range(0, 2))
                0:       begin rd = 1'b1; wm = 4'h0; end
                1:       begin rd = 1'b0; wm = 4'($urandom_range(1, 15)); end
                default: begin rd = 1'b1; wm = 4'($urandom_range(1, 15)); end
            endcase
            issue(a, rd, wm, $urandom, $urandom_range(1, TIMEOUT + 2));
            wait_retire();
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        end

        idle_cycles(3);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
